// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and the MEM-stage data port.
// Data wins contended decisions; a starvation counter periodically hands the memory to fetch.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic                               if_req_i,
    input  logic [ADDR_W-1:0]                  if_addr_i,
    output logic [DATA_W-1:0]                  if_rdata_o,
    output logic                               if_valid_o,
    output logic                               if_stall_o,

    input  logic                               d_req_i,
    input  logic                               d_we_i,
    input  logic [ADDR_W-1:0]                  d_addr_i,
    input  logic [DATA_W-1:0]                  d_wdata_i,
    input  logic [DATA_W/8-1:0]                d_be_i,
    output logic [DATA_W-1:0]                  d_rdata_o,
    output logic                               d_valid_o,
    output logic                               d_stall_o,

    output logic                               m_req_o,
    output logic                               m_we_o,
    output logic [ADDR_W-1:0]                  m_addr_o,
    output logic [DATA_W-1:0]                  m_wdata_o,
    output logic [DATA_W/8-1:0]                m_be_o,
    input  logic                               m_ack_i,
    input  logic [DATA_W-1:0]                  m_rdata_i,

    output logic                               err_o,

    output logic [1:0]                         dbg_state,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]  dbg_starve_cnt
);

    // Handshake: a port raises *_req_i and holds it (with stable fields) until its
    // *_valid_o pulse; requests are only sampled in IDLE, and the memory side holds
    // m_req_o with stable fields until m_ack_i (or the wait limit) ends the access.

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam bit                TIMEOUT_ON = (TIMEOUT != 0);

    logic [1:0]        state;
    logic [SC_W-1:0]   starve_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              gnt_data;

    logic both_req;
    logic grant_fetch;
    logic grant_data;
    logic ack_hit;
    logic timeout_hit;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        both_req    = if_req_i & d_req_i;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state == S_IDLE) begin
            if (both_req) begin
                grant_fetch = (starve_cnt == STARVE_MAX);
                grant_data  = ~grant_fetch;
            end else begin
                grant_fetch = if_req_i;
                grant_data  = d_req_i;
            end
        end
        // A late ack on the final wait cycle beats the timeout.
        ack_hit     = (state == S_BUSY) & m_ack_i;
        timeout_hit = (state == S_BUSY) & ~m_ack_i & TIMEOUT_ON & (wait_cnt == WAIT_LAST);
        resp_data   = ack_hit ? m_rdata_i : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            gnt_data   <= 1'b0;
            m_req_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_addr_o   <= '0;
            m_wdata_o  <= '0;
            m_be_o     <= '0;
            if_valid_o <= 1'b0;
            d_valid_o  <= 1'b0;
            err_o      <= 1'b0;
            if_rdata_o <= '0;
            d_rdata_o  <= '0;
        end else begin
            if_valid_o <= 1'b0;
            d_valid_o  <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_fetch) begin
                        starve_cnt <= '0;
                    end else if (grant_data && both_req && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + SC_W'(1);
                    end

                    if (grant_fetch || grant_data) begin
                        state    <= S_BUSY;
                        m_req_o  <= 1'b1;
                        wait_cnt <= '0;
                        gnt_data <= grant_data;
                        if (grant_data) begin
                            m_we_o    <= d_we_i;
                            m_addr_o  <= d_addr_i;
                            m_wdata_o <= d_wdata_i;
                            m_be_o    <= d_be_i;
                        end else begin
                            m_we_o    <= 1'b0;
                            m_addr_o  <= if_addr_i;
                            m_wdata_o <= '0;
                            m_be_o    <= '1;
                        end
                    end
                end

                S_BUSY: begin
                    if (ack_hit || timeout_hit) begin
                        state      <= S_RESP;
                        m_req_o    <= 1'b0;
                        if_valid_o <= ~gnt_data;
                        d_valid_o  <= gnt_data;
                        err_o      <= timeout_hit;
                        // Stores leave the load data register untouched.
                        if (!m_we_o) begin
                            if (gnt_data) begin
                                d_rdata_o <= resp_data;
                            end else begin
                                if_rdata_o <= resp_data;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    m_req_o <= 1'b0;
                end
            endcase
        end
    end

    assign if_stall_o     = if_req_i & ~if_valid_o;
    assign d_stall_o      = d_req_i & ~d_valid_o;
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(if_valid_o && d_valid_o));
    err_with_valid: assert property (@(posedge clk) disable iff (!rst_n)
        err_o |-> (if_valid_o || d_valid_o));
    req_only_busy: assert property (@(posedge clk) disable iff (!rst_n)
        m_req_o == (state == S_BUSY));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a spec-level cycle model checked every cycle,
// plus hand-computed literal expectations for latency, grant order and timeouts.
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int BE_W         = DATA_W / 8;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_valid_o, if_stall_o;
    logic              d_req_i = 1'b0, d_we_i = 1'b0;
    logic [ADDR_W-1:0] d_addr_i = '0;
    logic [DATA_W-1:0] d_wdata_i = '0;
    logic [BE_W-1:0]   d_be_i = '0;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_valid_o, d_stall_o;
    logic              m_req_o, m_we_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic [BE_W-1:0]   m_be_o;
    logic              m_ack_i = 1'b0;
    logic [DATA_W-1:0] m_rdata_i = '0;
    logic              err_o;
    logic [1:0]        dbg_state;
    logic [2:0]        dbg_starve_cnt;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_stall_o(d_stall_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_be_o(m_be_o), .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i),
        .err_o(err_o), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    // ack_delay = N acks in the Nth cycle of m_req_o; 0 never acks.
    int                ack_delay = 1;
    int                busy_n = 0;
    logic [DATA_W-1:0] mem_word = '0;

    always @(posedge clk) begin
        #1;
        if (m_req_o) begin
            busy_n++;
            m_ack_i = (ack_delay != 0) && (busy_n == ack_delay);
        end else begin
            busy_n  = 0;
            m_ack_i = 1'b0;
        end
        m_rdata_i = m_ack_i ? mem_word : 32'hBAD0_BAD0;
    end

    // ---------------- behavioural model ----------------
    // Tracks where the single outstanding access is (none / waiting on memory /
    // reporting) and what every output must be, from the arbitration rules.
    int                md_phase = 0;
    int                md_starve = 0;
    int                md_waited = 0;
    bit                md_to_data = 1'b0;
    bit                md_take_d, md_take_f;
    logic              md_m_req = 1'b0, md_we = 1'b0;
    logic [ADDR_W-1:0] md_addr = '0;
    logic [DATA_W-1:0] md_wdata = '0;
    logic [BE_W-1:0]   md_be = '0;
    logic              md_if_valid = 1'b0, md_d_valid = 1'b0, md_err = 1'b0;
    logic [DATA_W-1:0] md_if_rdata = '0, md_d_rdata = '0;
    string             grant_log = "";

    always @(posedge clk) begin
        if (!rst_n) begin
            md_phase = 0; md_starve = 0; md_waited = 0;
            md_m_req = 0; md_we = 0; md_addr = '0; md_wdata = '0; md_be = '0;
            md_if_valid = 0; md_d_valid = 0; md_err = 0;
            md_if_rdata = '0; md_d_rdata = '0;
        end else begin
            md_if_valid = 0; md_d_valid = 0; md_err = 0;
            if (md_phase == 0) begin
                md_take_f = 0; md_take_d = 0;
                if (if_req_i && d_req_i) begin
                    if (md_starve >= STARVE_LIMIT) md_take_f = 1; else md_take_d = 1;
                end else begin
                    md_take_f = if_req_i; md_take_d = d_req_i;
                end
                if (md_take_d) begin
                    if (if_req_i) md_starve = (md_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : md_starve + 1;
                    md_to_data = 1; md_we = d_we_i; md_addr = d_addr_i;
                    md_wdata = d_wdata_i; md_be = d_be_i;
                    grant_log = {grant_log, "D"};
                end else if (md_take_f) begin
                    md_starve = 0;
                    md_to_data = 0; md_we = 0; md_addr = if_addr_i;
                    md_wdata = '0; md_be = '1;
                    grant_log = {grant_log, "F"};
                end
                if (md_take_d || md_take_f) begin
                    md_phase = 1; md_waited = 0; md_m_req = 1;
                end
            end else if (md_phase == 1) begin
                md_waited++;
                if (m_ack_i || md_waited == TIMEOUT) begin
                    if (!md_we) begin
                        if (md_to_data) md_d_rdata = m_ack_i ? m_rdata_i : '0;
                        else md_if_rdata = m_ack_i ? m_rdata_i : '0;
                    end
                    md_if_valid = !md_to_data;
                    md_d_valid  = md_to_data;
                    md_err      = !m_ack_i;
                    md_m_req    = 0;
                    md_phase    = 2;
                end
            end else begin
                md_phase = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("m_req", m_req_o, md_m_req);
        if (md_m_req) begin
            chk("m_we", m_we_o, md_we);
            chk("m_addr", m_addr_o, md_addr);
            chk("m_wdata", m_wdata_o, md_wdata);
            chk("m_be", m_be_o, md_be);
        end
        chk("if_valid", if_valid_o, md_if_valid);
        chk("d_valid", d_valid_o, md_d_valid);
        chk("err", err_o, md_err);
        chk("if_rdata", if_rdata_o, md_if_rdata);
        chk("d_rdata", d_rdata_o, md_d_rdata);
        chk("if_stall", if_stall_o, if_req_i & ~md_if_valid);
        chk("d_stall", d_stall_o, d_req_i & ~md_d_valid);
        chk("starve_cnt", dbg_starve_cnt, 64'(md_starve));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for its valid pulse, check latency, memory
    // request length, err and read data, then drop the request.
    task automatic run_txn(input string name, input bit is_data, input bit we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input logic [BE_W-1:0] be, input int delay,
                           input logic [DATA_W-1:0] word, input logic [DATA_W-1:0] exp_rd,
                           input int exp_lat, input int exp_req_cyc, input bit exp_err);
        int  lat, req_cyc;
        bit  seen;
        logic [DATA_W-1:0] want;
        ack_delay = delay;
        mem_word  = word;
        if (!we) exp_q.push_back(exp_rd);
        if (is_data) begin
            d_we_i = we; d_addr_i = addr; d_wdata_i = wdata; d_be_i = be; d_req_i = 1'b1;
        end else begin
            if_addr_i = addr; if_req_i = 1'b1;
        end
        lat = 0; req_cyc = 0; seen = 0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (m_req_o) req_cyc++;
            seen = is_data ? d_valid_o : if_valid_o;
        end
        chk({name, "_seen"}, seen, 1'b1);
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_req_cycles"}, 64'(req_cyc), 64'(exp_req_cyc));
        chk({name, "_err"}, err_o, exp_err);
        if (!we && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk({name, "_rdata"}, is_data ? d_rdata_o : if_rdata_o, want);
        end
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        tick();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int lat, cnt;
        bit seen;

        repeat (3) tick();
        chk("rst_m_req", m_req_o, 1'b0);
        chk("rst_m_be", m_be_o, 4'h0);
        chk("rst_m_addr", m_addr_o, 32'h0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_valids", {if_valid_o, d_valid_o, err_o}, 3'b000);
        rst_n = 1'b1;
        tick();

        // Single fetch, 1-cycle ack: cycle-by-cycle literal expectations.
        ack_delay = 1; mem_word = 32'h0050_0093;
        if_addr_i = 32'h100; if_req_i = 1'b1;
        #1 chk("t1_stall_c0", if_stall_o, 1'b1);
        tick();
        chk("t1_m_req_c1", m_req_o, 1'b1);
        chk("t1_m_be_c1", m_be_o, 4'hF);
        chk("t1_m_we_c1", m_we_o, 1'b0);
        chk("t1_m_addr_c1", m_addr_o, 32'h100);
        chk("t1_stall_c1", if_stall_o, 1'b1);
        tick();
        chk("t1_valid_c2", if_valid_o, 1'b1);
        chk("t1_rdata_c2", if_rdata_o, 32'h0050_0093);
        chk("t1_stall_c2", if_stall_o, 1'b0);
        if_req_i = 1'b0;
        tick();
        chk("t1_valid_c3", if_valid_o, 1'b0);
        tick();

        // Store with 3-cycle ack; load data register must stay untouched.
        run_txn("store", 1, 1, 32'h2004, 32'hDEAD_BEEF, 4'h3, 3, 32'h1234_5678, '0, 4, 3, 0);
        chk("store_d_rdata_kept", d_rdata_o, 32'h0);

        // Load with 2-cycle ack.
        run_txn("load", 1, 0, 32'h3000, '0, 4'hF, 2, 32'h1122_3344, 32'h1122_3344, 3, 2, 0);

        // Data request that drops before it is granted is ignored.
        grant_log = "";
        ack_delay = 3; mem_word = 32'h0000_0013;
        if_addr_i = 32'h104; if_req_i = 1'b1;
        tick();
        d_we_i = 1'b0; d_addr_i = 32'h400; d_req_i = 1'b1;
        tick();
        d_req_i = 1'b0;
        seen = 0; cnt = 0;
        while (!seen && cnt < 20) begin tick(); cnt++; seen = if_valid_o; end
        chk("drop_pre_fetch_seen", seen, 1'b1);
        if_req_i = 1'b0;
        repeat (4) tick();
        checks++;
        if (grant_log != "F") begin
            errors++;
            $display("FAIL drop_pre_grants: got %s expected F", grant_log);
        end

        // Data request that drops right after being granted still completes.
        ack_delay = 2; mem_word = 32'h55AA_55AA;
        d_we_i = 1'b0; d_addr_i = 32'h44; d_req_i = 1'b1;
        tick();
        d_req_i = 1'b0;
        seen = 0; lat = 1;
        while (!seen && lat < 20) begin tick(); lat++; seen = d_valid_o; end
        chk("drop_post_seen", seen, 1'b1);
        chk("drop_post_lat", 64'(lat), 64'd3);
        chk("drop_post_rdata", d_rdata_o, 32'h55AA_55AA);
        tick();

        // Both ports hammering: data wins four times, then fetch once.
        grant_log = "";
        ack_delay = 1; mem_word = 32'hA5A5_0001;
        if_addr_i = 32'h200; d_addr_i = 32'h800; d_we_i = 1'b0; d_be_i = 4'hF;
        if_req_i = 1'b1; d_req_i = 1'b1;
        cnt = 0;
        while (grant_log.len() < 10 && cnt < 60) begin tick(); cnt++; end
        if_req_i = 1'b0; d_req_i = 1'b0;
        repeat (4) tick();
        checks++;
        if (grant_log != "DDDDFDDDDF") begin
            errors++;
            $display("FAIL grant_order: got %s expected DDDDFDDDDF", grant_log);
        end
        chk("starve_after_fetch", dbg_starve_cnt, 3'd0);

        // Memory never acks: 8 request cycles, then valid with err and zero data.
        run_txn("timeout", 0, 0, 32'h300, '0, '0, 0, 32'hFFFF_FFFF, 32'h0, 9, 8, 1);
        chk("timeout_idle_after", m_req_o, 1'b0);

        // Ack lands on the final wait cycle: ack wins, no err.
        run_txn("ack_at_expiry", 0, 0, 32'h304, '0, '0, 8, 32'hCAFE_F00D, 32'hCAFE_F00D, 9, 8, 0);

        // Reset in the middle of an outstanding load abandons it.
        ack_delay = 0; mem_word = 32'h7777_7777;
        d_we_i = 1'b0; d_addr_i = 32'h80; d_req_i = 1'b1;
        repeat (3) tick();
        chk("rst_busy_pre", m_req_o, 1'b1);
        rst_n = 1'b0; d_req_i = 1'b0;
        tick();
        chk("rst_busy_m_req", m_req_o, 1'b0);
        chk("rst_busy_d_valid", d_valid_o, 1'b0);
        chk("rst_busy_d_rdata", d_rdata_o, 32'h0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin tick(); if (d_valid_o) cnt++; end
        chk("rst_busy_no_valid", 64'(cnt), 64'd0);

        run_txn("post_rst_fetch", 0, 0, 32'h100, '0, '0, 1, 32'h0010_0073, 32'h0010_0073, 2, 1, 0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
